// File: rtl/osc_rst_pkg.sv
// Shared state encoding and sizing helpers for the oscillator-domain reset sequencer.
package osc_rst_pkg;

    typedef enum logic [2:0] {
        StHold     = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StStretch  = 3'd4
    } state_e;

    localparam int unsigned LossCntW = 8;

    // One counter width covers the stabilisation count, activity timer and stretch count.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/osc_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous bit, with synchronous clear.
module osc_sync_bit #(
    parameter int unsigned SyncStages = 2
) (
    input  logic clk_i,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic [SyncStages-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], d_i};
        end
    end

    assign q_o = sync_q[SyncStages-1];

endmodule

// File: rtl/osc_clk_reset_sequencer.sv
// Releases system reset once the CCC PLL is locked and its output is toggling, and re-asserts
// it (recording a fault) on lock loss, activity loss or a software request.
module osc_clk_reset_sequencer
    import osc_rst_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned ACT_TIMEOUT        = 64,
    parameter int unsigned RST_STRETCH        = 16,
    parameter int unsigned SYNC_STAGES        = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                PLL_LOCK,
    input  logic                CCC_TOGGLE,
    input  logic                SW_RESET_REQ,
    input  logic                FAULT_CLR,
    output logic                SYS_RESET_N,
    output logic                FABRIC_READY,
    output logic                FAULT,
    output logic [2:0]          STATE,
    output logic [LossCntW-1:0] LOCK_LOSS_CNT
);

    localparam int unsigned CntW = cnt_width(LOCK_STABLE_CYCLES, ACT_TIMEOUT + 1, RST_STRETCH);
    localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] StretchLast = CntW'(RST_STRETCH - 1);
    localparam logic [CntW-1:0] ActMax      = CntW'(ACT_TIMEOUT);

    logic lock_s;
    logic tog_s;
    logic tog_prev_q;
    logic tog_edge;
    logic act_lost;

    logic [CntW-1:0]     act_timer_q;
    logic [CntW-1:0]     cnt_q;
    state_e              state_q;
    logic                sys_rst_n_q;
    logic                ready_q;
    logic                fault_q;
    logic [LossCntW-1:0] loss_cnt_q;

    osc_sync_bit #(
        .SyncStages(SYNC_STAGES)
    ) u_sync_lock (
        .clk_i(CLK),
        .clr_i(RESET),
        .d_i  (PLL_LOCK),
        .q_o  (lock_s)
    );

    osc_sync_bit #(
        .SyncStages(SYNC_STAGES)
    ) u_sync_tog (
        .clk_i(CLK),
        .clr_i(RESET),
        .d_i  (CCC_TOGGLE),
        .q_o  (tog_s)
    );

    assign tog_edge = tog_s ^ tog_prev_q;
    assign act_lost = (act_timer_q == ActMax);

    // Activity timer runs in every state; only STABLE and RUN act on it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tog_prev_q  <= 1'b0;
            act_timer_q <= '0;
        end else begin
            tog_prev_q <= tog_s;
            if (tog_edge) begin
                act_timer_q <= '0;
            end else if (!act_lost) begin
                act_timer_q <= act_timer_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StHold;
            cnt_q       <= '0;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            loss_cnt_q  <= '0;
        end else begin
            ready_q <= sys_rst_n_q;
            // A fault set further down wins over a coincident clear.
            if (FAULT_CLR) fault_q <= 1'b0;
            unique case (state_q)
                StHold: state_q <= StWaitLock;
                StWaitLock: begin
                    cnt_q <= '0;
                    if (lock_s) state_q <= StStable;
                end
                StStable: begin
                    if (!lock_s || act_lost) begin
                        state_q <= StWaitLock;
                    end else if (cnt_q == StableLast) begin
                        state_q     <= StRun;
                        sys_rst_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StRun: begin
                    if (!lock_s || act_lost || SW_RESET_REQ) begin
                        state_q     <= StStretch;
                        sys_rst_n_q <= 1'b0;
                        cnt_q       <= '0;
                        if (!lock_s) begin
                            fault_q <= 1'b1;
                            if (loss_cnt_q != '1) loss_cnt_q <= loss_cnt_q + LossCntW'(1);
                        end
                        if (act_lost) fault_q <= 1'b1;
                    end
                end
                StStretch: begin
                    if (cnt_q == StretchLast) begin
                        state_q <= StWaitLock;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StHold;
            endcase
        end
    end

    assign SYS_RESET_N   = sys_rst_n_q;
    assign FABRIC_READY  = ready_q;
    assign FAULT         = fault_q;
    assign STATE         = state_q;
    assign LOCK_LOSS_CNT = loss_cnt_q;

endmodule

// File: tb/tb_osc_clk_reset_sequencer.sv
// Bench for osc_clk_reset_sequencer: directed scenarios plus random stimulus against a
// cycle-level behavioural model of the sequencing rules.
module tb_osc_clk_reset_sequencer;

    localparam int L = 16;
    localparam int T = 8;
    localparam int R = 4;
    localparam int S = 2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       PLL_LOCK = 1'b0;
    logic       CCC_TOGGLE = 1'b0;
    logic       SW_RESET_REQ = 1'b0;
    logic       FAULT_CLR = 1'b0;
    logic       SYS_RESET_N;
    logic       FABRIC_READY;
    logic       FAULT;
    logic [2:0] STATE;
    logic [7:0] LOCK_LOSS_CNT;
    logic [13:0] dut_vec;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit tog_en = 1'b1;
    int tog_ph = 0;
    int last_flip = 0;

    // Behavioural model state
    int m_st, m_cnt, m_quiet, m_lc;
    bit m_sys, m_rdy, m_fault, m_tog_seen;
    bit lock_hist[$];
    bit tog_hist[$];

    osc_clk_reset_sequencer #(
        .LOCK_STABLE_CYCLES(L),
        .ACT_TIMEOUT       (T),
        .RST_STRETCH       (R),
        .SYNC_STAGES       (S)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PLL_LOCK     (PLL_LOCK),
        .CCC_TOGGLE   (CCC_TOGGLE),
        .SW_RESET_REQ (SW_RESET_REQ),
        .FAULT_CLR    (FAULT_CLR),
        .SYS_RESET_N  (SYS_RESET_N),
        .FABRIC_READY (FABRIC_READY),
        .FAULT        (FAULT),
        .STATE        (STATE),
        .LOCK_LOSS_CNT(LOCK_LOSS_CNT)
    );

    assign dut_vec = {STATE, SYS_RESET_N, FABRIC_READY, FAULT, LOCK_LOSS_CNT};

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d total=%0d bad=%0d", cyc, total, bad);
        $fatal(1);
    end

    function automatic logic [13:0] exp_vec();
        return {3'(m_st), m_sys, m_rdy, m_fault, 8'(m_lc)};
    endfunction

    // Advance the model by one CLK edge using the inputs seen at that edge.
    function automatic void model_edge(bit rst, bit lk, bit tg, bit sw, bit clr);
        bit ls, lost, nf, osys;
        if (rst) begin
            m_st = 0; m_cnt = 0; m_quiet = 0; m_lc = 0;
            m_sys = 0; m_rdy = 0; m_fault = 0; m_tog_seen = 0;
            lock_hist = {};
            tog_hist = {};
            repeat (S) begin
                lock_hist.push_back(1'b0);
                tog_hist.push_back(1'b0);
            end
            return;
        end
        ls   = lock_hist[0];
        lost = (m_quiet == T);
        nf   = 1'b0;
        osys = m_sys;
        case (m_st)
            0: m_st = 1;
            1: begin
                m_cnt = 0;
                if (ls) m_st = 2;
            end
            2: begin
                if (!ls || lost) m_st = 1;
                else if (m_cnt == L - 1) begin m_st = 3; m_sys = 1; end
                else m_cnt++;
            end
            3: begin
                if (!ls || lost || sw) begin
                    m_st = 4; m_sys = 0; m_cnt = 0;
                    if (!ls) begin nf = 1; m_lc = (m_lc < 255) ? m_lc + 1 : 255; end
                    if (lost) nf = 1;
                end
            end
            default: begin
                if (m_cnt == R - 1) m_st = 1;
                else m_cnt++;
            end
        endcase
        m_rdy = osys;
        if (nf) m_fault = 1;
        else if (clr) m_fault = 0;
        m_quiet = (tog_hist[0] != m_tog_seen) ? 0 : ((m_quiet < T) ? m_quiet + 1 : T);
        m_tog_seen = tog_hist[0];
        lock_hist.push_back(lk);
        void'(lock_hist.pop_front());
        tog_hist.push_back(tg);
        void'(tog_hist.pop_front());
    endfunction

    task automatic step();
        @(posedge CLK);
        model_edge(RESET, PLL_LOCK, CCC_TOGGLE, SW_RESET_REQ, FAULT_CLR);
        cyc++;
        #1;
        SW_RESET_REQ = 1'b0;
        FAULT_CLR = 1'b0;
        if (tog_en) begin
            tog_ph++;
            if (tog_ph == 3) begin
                tog_ph = 0;
                CCC_TOGGLE = ~CCC_TOGGLE;
                last_flip = cyc;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (5) begin
            step();
            total++;
            if (dut_vec !== 14'd0) begin
                bad++;
                $display("FAIL reset_vals cyc=%0d got=%h want=0", cyc, dut_vec);
            end
        end
    endtask

    task automatic test_power_up();
        int rise, rdy_rise, exp_st;
        rise = 0;
        rdy_rise = 0;
        RESET = 1'b0;
        PLL_LOCK = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL pwr_track cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec());
            end
            if (SYS_RESET_N === 1'b1 && rise == 0) rise = n;
            if (FABRIC_READY === 1'b1 && rdy_rise == 0) rdy_rise = n;
            if (n == 1 || n == 3 || n == 19) begin
                exp_st = (n == 1) ? 1 : ((n == 3) ? 2 : 3);
                total++;
                if (STATE !== 3'(exp_st)) begin
                    bad++;
                    $display("FAIL pwr_state edge=%0d got=%0d want=%0d", n, STATE, exp_st);
                end
            end
        end
        // The edge that first samples PLL_LOCK high is counted as edge 1.
        total++;
        if (rise != 19) begin bad++; $display("FAIL pwr_rise got=%0d want=19", rise); end
        total++;
        if (rdy_rise != 20) begin bad++; $display("FAIL pwr_ready got=%0d want=20", rdy_rise); end
        total++;
        if (FAULT !== 1'b0) begin bad++; $display("FAIL pwr_fault got=%b want=0", FAULT); end
    endtask

    task automatic test_lock_drop_stable();
        bit saw_wait, sys_seen;
        saw_wait = 0;
        sys_seen = 0;
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
        for (int i = 0; i < 10 && STATE !== 3'd2; i++) begin
            step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL stdrop_track cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec());
            end
        end
        repeat (10) begin
            step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL stdrop_track cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec());
            end
        end
        PLL_LOCK = 1'b0;
        repeat (6) begin
            step();
            if (STATE === 3'd1) saw_wait = 1;
            if (SYS_RESET_N !== 1'b0) sys_seen = 1;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL stdrop_track cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec());
            end
        end
        PLL_LOCK = 1'b1;
        total++;
        if (saw_wait != 1) begin bad++; $display("FAIL stdrop_wait got=0 want=1"); end
        total++;
        if (sys_seen != 0) begin bad++; $display("FAIL stdrop_sysrst got=1 want=0"); end
        total++;
        if (LOCK_LOSS_CNT !== 8'd0) begin
            bad++;
            $display("FAIL stdrop_losscnt got=%0d want=0", LOCK_LOSS_CNT);
        end
        for (int i = 0; i < 40 && SYS_RESET_N !== 1'b1; i++) begin
            step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL stdrop_track cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec());
            end
        end
        total++;
        if (STATE !== 3'd3) begin bad++; $display("FAIL stdrop_relock got=%0d want=3", STATE); end
    endtask

    task automatic test_lock_loss_run();
        int rise;
        rise = 0;
        PLL_LOCK = 1'b0;
        step();
        total++;
        if (STATE !== 3'd3 || SYS_RESET_N !== 1'b1) begin
            bad++;
            $display("FAIL runloss_e1 got=%0d/%b want=3/1", STATE, SYS_RESET_N);
        end
        step();
        total++;
        if (STATE !== 3'd3) begin bad++; $display("FAIL runloss_e2 got=%0d want=3", STATE); end
        PLL_LOCK = 1'b1;
        step();
        total++;
        if ({STATE, SYS_RESET_N, FAULT, LOCK_LOSS_CNT} !== {3'd4, 1'b0, 1'b1, 8'd1}) begin
            bad++;
            $display("FAIL runloss_enter got=%0d/%b/%b/%0d want=4/0/1/1",
                     STATE, SYS_RESET_N, FAULT, LOCK_LOSS_CNT);
        end
        for (int n = 1; n <= 3; n++) begin
            step();
            total++;
            if (STATE !== 3'd4) begin
                bad++;
                $display("FAIL runloss_stretch n=%0d got=%0d want=4", n, STATE);
            end
        end
        step();
        total++;
        if (STATE !== 3'd1) begin bad++; $display("FAIL runloss_wait got=%0d want=1", STATE); end
        for (int n = 1; n <= 30 && rise == 0; n++) begin
            step();
            if (SYS_RESET_N === 1'b1) rise = n;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL runloss_track cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec());
            end
        end
        total++;
        if (rise != 17) begin bad++; $display("FAIL runloss_relock got=%0d want=17", rise); end
    endtask

    task automatic test_act_loss();
        int entry;
        entry = 0;
        tog_en = 1'b0;
        for (int i = 0; i < 30 && entry == 0; i++) begin
            step();
            if (STATE === 3'd4) entry = cyc;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL act_track cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec());
            end
        end
        total++;
        if (entry != last_flip + S + T + 2) begin
            bad++;
            $display("FAIL act_entry got=%0d want=%0d", entry, last_flip + S + T + 2);
        end
        total++;
        if (FAULT !== 1'b1 || LOCK_LOSS_CNT !== 8'd1) begin
            bad++;
            $display("FAIL act_effect got=%b/%0d want=1/1", FAULT, LOCK_LOSS_CNT);
        end
        tog_en = 1'b1;
        tog_ph = 0;
        for (int i = 0; i < 80 && STATE !== 3'd3; i++) begin
            step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL act_track cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec());
            end
        end
        total++;
        if (STATE !== 3'd3) begin bad++; $display("FAIL act_rerun got=%0d want=3", STATE); end
    endtask

    task automatic test_sw_req();
        FAULT_CLR = 1'b1;
        step();
        total++;
        if (FAULT !== 1'b0) begin bad++; $display("FAIL sw_clr got=%b want=0", FAULT); end
        SW_RESET_REQ = 1'b1;
        step();
        total++;
        if ({STATE, SYS_RESET_N, FAULT} !== {3'd4, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL sw_enter got=%0d/%b/%b want=4/0/0", STATE, SYS_RESET_N, FAULT);
        end
        for (int i = 0; i < 20 && STATE !== 3'd2; i++) begin
            step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL sw_track cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec());
            end
        end
        SW_RESET_REQ = 1'b1;
        step();
        total++;
        if (STATE !== 3'd2) begin bad++; $display("FAIL sw_ignored got=%0d want=2", STATE); end
        for (int i = 0; i < 30 && STATE !== 3'd3; i++) begin
            step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL sw_track cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec());
            end
        end
        total++;
        if (STATE !== 3'd3) begin bad++; $display("FAIL sw_rerun got=%0d want=3", STATE); end
    endtask

    task automatic test_fault_clr_coincident();
        PLL_LOCK = 1'b0;
        step();
        step();
        PLL_LOCK = 1'b1;
        FAULT_CLR = 1'b1;
        step();
        total++;
        if ({STATE, FAULT, LOCK_LOSS_CNT} !== {3'd4, 1'b1, 8'd2}) begin
            bad++;
            $display("FAIL clr_coincide got=%0d/%b/%0d want=4/1/2", STATE, FAULT, LOCK_LOSS_CNT);
        end
        FAULT_CLR = 1'b1;
        step();
        total++;
        if (FAULT !== 1'b0) begin bad++; $display("FAIL clr_alone got=%b want=0", FAULT); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if (PLL_LOCK) PLL_LOCK = ($urandom_range(59, 0) != 0);
            else PLL_LOCK = ($urandom_range(3, 0) == 0);
            if (tog_en) tog_en = ($urandom_range(149, 0) != 0);
            else tog_en = ($urandom_range(5, 0) == 0);
            SW_RESET_REQ = ($urandom_range(24, 0) == 0);
            FAULT_CLR = ($urandom_range(29, 0) == 0);
            RESET = ($urandom_range(699, 0) == 0);
            step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL rand_track cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec());
            end
        end
        RESET = 1'b0;
    endtask

    task automatic test_saturate();
        RESET = 1'b0;
        PLL_LOCK = 1'b1;
        tog_en = 1'b1;
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 80 && STATE !== 3'd3; i++) begin
                step();
                total++;
                if (dut_vec !== exp_vec()) begin
                    bad++;
                    $display("FAIL sat_track cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec());
                end
            end
            repeat ($urandom_range(4, 0)) step();
            PLL_LOCK = 1'b0;
            repeat ($urandom_range(3, 1)) step();
            PLL_LOCK = 1'b1;
            for (int i = 0; i < 10 && STATE === 3'd3; i++) begin
                step();
                total++;
                if (dut_vec !== exp_vec()) begin
                    bad++;
                    $display("FAIL sat_track cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec());
                end
            end
        end
        total++;
        if (LOCK_LOSS_CNT !== 8'd255) begin
            bad++;
            $display("FAIL sat_count got=%0d want=255", LOCK_LOSS_CNT);
        end
    endtask

    task automatic test_reset_mid_stable();
        SW_RESET_REQ = 1'b1;
        for (int i = 0; i < 60 && STATE !== 3'd2; i++) begin
            step();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL midrst_track cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec());
            end
        end
        repeat (3) step();
        total++;
        if (STATE !== 3'd2) begin bad++; $display("FAIL midrst_stable got=%0d want=2", STATE); end
        RESET = 1'b1;
        step();
        total++;
        if (dut_vec !== 14'd0) begin
            bad++;
            $display("FAIL midrst_vals got=%h want=0", dut_vec);
        end
        RESET = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_lock_drop_stable();
        test_lock_loss_run();
        test_act_loss();
        test_sw_req();
        test_fault_clr_coincident();
        test_random();
        test_saturate();
        test_reset_mid_stable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
